johnson_code_decoder: RTL

//  Receive end of the twisted-ring (Johnson) counter interface. Samples an N-bit Johnson

---
 rtl/johnson_code_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/johnson_code_decoder.sv
// johnson_code_decoder
// Receive side of a twisted-ring (Johnson) counter link. Decodes each valid
// N-bit Johnson sample to a binary index, tracks whether the sequence is
// stepping legally (hold or successor), and reports lock and error status.
//
// Optional feature: define JOHNSON_DEC_ERRCNT_EN to build the saturating
// error counter behind err_count. Without it err_count is tied to zero.
module johnson_code_decoder #(
    parameter int N         = 4,
    parameter int IDX_W     = 3,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N-1:0]         code_in,
    output logic [IDX_W-1:0]     idx_out,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 code_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       run;
    logic [3:0]       run_nx;
    logic [3:0]       run_inc;
    logic [IDX_W-1:0] prev;
    logic [IDX_W-1:0] prev_nx;
    logic             have_prev;
    logic             have_prev_nx;

    logic [IDX_W-1:0] idx_nx;
    logic             idx_valid_nx;
    logic             locked_nx;
    logic             code_err_nx;
    logic             seq_err_nx;

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] succ;
    logic             is_succ;
    logic             is_hold;

    // Johnson pattern for index i, MSB first: indices 0..N fill ones from the
    // top, indices N+1..2N-1 then clear ones from the top.
    function automatic logic [N-1:0] johnson_pattern(input int i);
        logic [N-1:0] pat;
        int           p;
        pat = '0;
        for (int b = 0; b < N; b++) begin
            p = N - 1 - b;
            if (i <= N) begin
                pat[b] = (p < i);
            end else begin
                pat[b] = (p >= (i - N));
            end
        end
        return pat;
    endfunction

    // Match the sample against every legal pattern; no match means illegal.
    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (code_in == johnson_pattern(i)) begin
                dec_legal = 1'b1;
                dec_idx   = IDX_W'(i);
            end
        end
    end

    // Successor of the previous index wraps from 2N-1 back to 0.
    always_comb begin
        succ    = (prev == IDX_W'(2 * N - 1)) ? '0 : prev + IDX_W'(1);
        is_succ = (dec_idx == succ);
        is_hold = (dec_idx == prev);
        run_inc = run + 4'd1;
    end

    // Next-state and next-output logic for the HUNT/LOCKED tracker.
    always_comb begin
        state_nx     = state;
        run_nx       = run;
        prev_nx      = prev;
        have_prev_nx = have_prev;
        idx_nx       = idx_out;
        idx_valid_nx = 1'b0;
        code_err_nx  = 1'b0;
        seq_err_nx   = 1'b0;

        if (in_valid) begin
            if (!dec_legal) begin
                code_err_nx  = 1'b1;
                state_nx     = HUNT;
                run_nx       = '0;
                have_prev_nx = 1'b0;
            end else begin
                idx_valid_nx = 1'b1;
                idx_nx       = dec_idx;
                prev_nx      = dec_idx;
                have_prev_nx = 1'b1;
                case (state)
                    HUNT: begin
                        if (!have_prev) begin
                            run_nx = '0;
                        end else if (is_succ) begin
                            if (run_inc == 4'(LOCK_CNT)) begin
                                state_nx = LOCKED;
                                run_nx   = '0;
                            end else begin
                                run_nx = run_inc;
                            end
                        end else if (!is_hold) begin
                            run_nx = '0;
                        end
                    end
                    LOCKED: begin
                        if (!(is_succ || is_hold)) begin
                            seq_err_nx = 1'b1;
                            state_nx   = HUNT;
                            run_nx     = '0;
                        end
                    end
                    default: begin
                        state_nx = HUNT;
                        run_nx   = '0;
                    end
                endcase
            end
        end

        locked_nx = (state_nx == LOCKED);
    end

    // State and output registers; reset drops lock and clears all history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            run       <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            idx_out   <= '0;
            idx_valid <= 1'b0;
            locked    <= 1'b0;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            run       <= run_nx;
            prev      <= prev_nx;
            have_prev <= have_prev_nx;
            idx_out   <= idx_nx;
            idx_valid <= idx_valid_nx;
            locked    <= locked_nx;
            code_err  <= code_err_nx;
            seq_err   <= seq_err_nx;
        end
    end

`ifdef JOHNSON_DEC_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating count of error pulses, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if ((code_err_nx || seq_err_nx) && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule
